// File: rtl/drum_timing_gen_pkg.sv
// Shared G-15 drum timing constants, counter types and matcher state encoding.
package g15_timing_pkg;

    localparam int unsigned BITS_PER_WORD_C = 29;
    localparam int unsigned WORDS_PER_REV_C = 108;
    localparam int unsigned TRACK_LEN_C     = BITS_PER_WORD_C * WORDS_PER_REV_C;

    typedef logic [4:0] bit_time_t;
    typedef logic [6:0] word_time_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HIT
    } match_state_t;

endpackage

// File: rtl/drum_timing_gen_if.sv
// Word-location match handshake between command control (master) and the timing generator (slave).
interface drum_timing_gen_if;

    logic       ARM;
    logic [6:0] TARGET;
    logic       BUSY;
    logic       MATCH;
    logic       DONE;
    logic       TERR;

    modport master (output ARM, TARGET, input BUSY, MATCH, DONE, TERR);
    modport slave  (input ARM, TARGET, output BUSY, MATCH, DONE, TERR);

endinterface

// File: rtl/drum_timing_gen_matcher.sv
// One-shot word-location matcher: arms on a target word, gates exactly one
// full word starting at its T0, then returns to idle.
module word_matcher
    import g15_timing_pkg::*;
#(
    parameter int unsigned BITS_PER_WORD = BITS_PER_WORD_C,
    parameter int unsigned WORDS_PER_REV = WORDS_PER_REV_C
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  bit_time_t  bt_i,
    input  word_time_t wt_i,
    input  logic       arm_i,
    input  word_time_t target_i,
    output logic       busy_o,
    output logic       match_o,
    output logic       done_o,
    output logic       terr_o
);

    localparam bit_time_t  LAST_BIT  = bit_time_t'(BITS_PER_WORD - 1);
    localparam word_time_t LAST_WORD = word_time_t'(WORDS_PER_REV - 1);

    match_state_t state_q;
    word_time_t   target_q;
    logic         terr_q;
    logic         hit_now;
    logic         target_ok;

    assign target_ok = (target_i <= LAST_WORD);
    // Only a WAIT that sees T0 of the target word hits; arming mid-word waits a revolution.
    assign hit_now   = (state_q == WAIT) && (bt_i == '0) && (wt_i == target_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            target_q <= '0;
            terr_q   <= 1'b0;
        end else begin
            terr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (arm_i) begin
                        if (target_ok) begin
                            target_q <= target_i;
                            state_q  <= WAIT;
                        end else begin
                            terr_q <= 1'b1;
                        end
                    end
                end
                WAIT:    if (hit_now) state_q <= HIT;
                HIT:     if (bt_i == LAST_BIT) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign match_o = (state_q == HIT) || hit_now;
    assign done_o  = (state_q == HIT) && (bt_i == LAST_BIT);
    assign terr_o  = terr_q;

endmodule

// File: rtl/drum_timing_gen.sv
// Free-running drum bit-time/word-time generator with decoded strobes and a
// one-shot word-location matcher.
module drum_timing_gen
    import g15_timing_pkg::*;
#(
    parameter int unsigned BITS_PER_WORD = BITS_PER_WORD_C,
    parameter int unsigned WORDS_PER_REV = WORDS_PER_REV_C
) (
    input  logic              CLOCK,
    input  logic              RST_N,
    drum_timing_gen_if.slave  mif,
    output logic [4:0]        BT,
    output logic [6:0]        WT,
    output logic              T0,
    output logic              T1,
    output logic              T28,
    output logic              WEVEN,
    output logic              REV0
);

    localparam bit_time_t  LAST_BIT  = bit_time_t'(BITS_PER_WORD - 1);
    localparam word_time_t LAST_WORD = word_time_t'(WORDS_PER_REV - 1);

    bit_time_t  bt_q, bt_d;
    word_time_t wt_q, wt_d;

    always_comb begin
        bt_d = bt_q + 5'd1;
        wt_d = wt_q;
        if (bt_q == LAST_BIT) begin
            bt_d = '0;
            wt_d = (wt_q == LAST_WORD) ? '0 : wt_q + 7'd1;
        end
    end

    always_ff @(posedge CLOCK or negedge RST_N) begin
        if (!RST_N) begin
            bt_q <= '0;
            wt_q <= '0;
        end else begin
            bt_q <= bt_d;
            wt_q <= wt_d;
        end
    end

    assign BT    = bt_q;
    assign WT    = wt_q;
    assign T0    = (bt_q == '0);
    assign T1    = (bt_q == 5'd1);
    assign T28   = (bt_q == LAST_BIT);
    assign WEVEN = ~wt_q[0];
    assign REV0  = (bt_q == '0) && (wt_q == '0);

    word_matcher #(
        .BITS_PER_WORD (BITS_PER_WORD),
        .WORDS_PER_REV (WORDS_PER_REV)
    ) u_matcher (
        .clk_i    (CLOCK),
        .rst_ni   (RST_N),
        .bt_i     (bt_q),
        .wt_i     (wt_q),
        .arm_i    (mif.ARM),
        .target_i (mif.TARGET),
        .busy_o   (mif.BUSY),
        .match_o  (mif.MATCH),
        .done_o   (mif.DONE),
        .terr_o   (mif.TERR)
    );

endmodule

// File: tb/tb_drum_timing_gen.sv
// Bench for drum_timing_gen: per-cycle reference model, table of arm vectors,
// scoreboard of expected match windows, and hand-written reset/ignore sequences.
module tb_drum_timing_gen;

    localparam int NB = 29;
    localparam int NW = 108;
    localparam int NT = NB * NW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    drum_timing_gen_if mif ();
    logic [4:0] bt;
    logic [6:0] wt;
    logic t0, t1, t28, weven, rev0;

    drum_timing_gen #(.BITS_PER_WORD(29), .WORDS_PER_REV(108)) dut (
        .CLOCK (clk),
        .RST_N (rst_n),
        .mif   (mif),
        .BT    (bt),
        .WT    (wt),
        .T0    (t0),
        .T1    (t1),
        .T28   (t28),
        .WEVEN (weven),
        .REV0  (rev0)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a linear track position instead of separate bit/word counters.
    int   pos, ms, mt, cyc;
    logic mterr;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos   <= 0;
            ms    <= 0;
            mt    <= 0;
            mterr <= 1'b0;
        end else begin
            pos   <= (pos == NT - 1) ? 0 : pos + 1;
            mterr <= (ms == 0) && mif.ARM && (int'(mif.TARGET) >= NW);
            case (ms)
                0: if (mif.ARM && int'(mif.TARGET) < NW) begin ms <= 1; mt <= int'(mif.TARGET); end
                1: if (pos == mt * NB) ms <= 2;
                2: if (pos % NB == NB - 1) ms <= 0;
                default: ms <= 0;
            endcase
        end
    end

    function automatic logic [20:0] model_out();
        int   b = pos % NB;
        int   w = pos / NB;
        logic m = (ms == 2) || (ms == 1 && pos == mt * NB);
        return {5'(b), 7'(w), b == 0, b == 1, b == NB - 1, (w % 2) == 0, pos == 0,
                ms != 0, m, (ms == 2) && (b == NB - 1), mterr};
    endfunction

    typedef struct { int start; int target; } sb_t;
    sb_t sb[$];

    // Monitor: full output compare every cycle, plus match-window scoreboard.
    initial begin
        int   mstart, mwidth;
        logic mprev;
        sb_t  e;
        mstart = 0; mwidth = 0; mprev = 1'b0;
        forever begin
            @(negedge clk);
            check("outputs", 32'({bt, wt, t0, t1, t28, weven, rev0,
                                  mif.BUSY, mif.MATCH, mif.DONE, mif.TERR}), 32'(model_out()));
            if (!rst_n) begin
                mwidth = 0;
                mprev  = 1'b0;
            end else begin
                if (mif.MATCH) begin
                    if (!mprev) begin mstart = cyc; mwidth = 0; end
                    mwidth++;
                end
                mprev = mif.MATCH;
                if (mif.DONE) begin
                    check("sb_nonempty_on_done", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("match_start_cycle", 32'(mstart), 32'(e.start));
                        check("match_width", 32'(mwidth), 32'(NB));
                        check("match_word", 32'(wt), 32'(e.target));
                    end
                end
            end
        end
    end

    task automatic arm_at(input int apos, input int target, input int delay, input logic exp_terr);
        int n = 0;
        @(negedge clk);
        while (!(ms == 0 && pos == apos) && n < 3 * NT) begin
            @(negedge clk);
            n++;
        end
        check("arm_wait_timeout", 32'(n < 3 * NT), 32'd1);
        mif.ARM    = 1'b1;
        mif.TARGET = 7'(target);
        if (!exp_terr) sb.push_back('{cyc + delay, target});
        @(negedge clk);
        mif.ARM = 1'b0;
        check("terr_after_arm", 32'(mif.TERR), 32'(exp_terr));
        check("busy_after_arm", 32'(mif.BUSY), 32'(!exp_terr));
    endtask

    typedef struct { int apos; int target; int delay; logic terr; } vec_t;
    vec_t vecs[6];

    initial begin
        int t28c, rev0c, n;
        vecs[0] = '{68,   5,   77,   1'b0};  // word 2 bit 10 -> word 5
        vecs[1] = '{148,  5,   3129, 1'b0};  // word 5 bit 3 -> next revolution
        vecs[2] = '{3000, 107, 103,  1'b0};  // last word before the wrap
        vecs[3] = '{3100, 0,   32,   1'b0};  // first word after REV0
        vecs[4] = '{10,   108, 0,    1'b1};  // out of range
        vecs[5] = '{289,  10,  1,    1'b0};  // minimum latency
        mif.ARM = 1'b0;
        mif.TARGET = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_bt", 32'(bt), 32'd0);
        check("rst_t0", 32'(t0), 32'd1);
        check("rst_rev0", 32'(rev0), 32'd1);
        check("rst_busy", 32'(mif.BUSY), 32'd0);
        rst_n = 1'b1;

        t28c = 0; rev0c = 0;
        for (int i = 0; i <= NT; i++) begin
            @(negedge clk);
            if (i < NT) t28c += int'(t28);
            rev0c += int'(rev0);
            if (i == NT - 1) check("wt_last", 32'(wt), 32'd107);
            if (i == NT) begin
                check("wt_wrap", 32'(wt), 32'd0);
                check("bt_wrap", 32'(bt), 32'd0);
            end
        end
        check("t28_count", 32'(t28c), 32'd108);
        check("rev0_count", 32'(rev0c), 32'd2);

        for (int v = 0; v < 6; v++)
            arm_at(vecs[v].apos, vecs[v].target, vecs[v].delay, vecs[v].terr);

        // Second ARM while waiting on word 20 must be ignored.
        arm_at(500, 20, 80, 1'b0);
        repeat (4) @(negedge clk);
        mif.ARM = 1'b1;
        mif.TARGET = 7'd40;
        @(negedge clk);
        mif.ARM = 1'b0;
        check("ignored_arm_terr", 32'(mif.TERR), 32'd0);
        check("ignored_arm_busy", 32'(mif.BUSY), 32'd1);
        repeat (800) @(negedge clk);

        // Reset in the middle of a HIT.
        arm_at(2000, 70, 30, 1'b0);
        n = 0;
        while (!(ms == 2 && pos % NB == 12) && n < 2 * NT) begin
            @(negedge clk);
            n++;
        end
        check("hit_wait_timeout", 32'(n < 2 * NT), 32'd1);
        check("pre_reset_match", 32'(mif.MATCH), 32'd1);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("reset_match", 32'(mif.MATCH), 32'd0);
        check("reset_busy", 32'(mif.BUSY), 32'd0);
        check("reset_done", 32'(mif.DONE), 32'd0);
        check("reset_bt_wt", 32'({bt, wt}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_bt", 32'(bt), 32'd0);
        check("post_reset_wt", 32'(wt), 32'd0);
        arm_at(30, 3, 57, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 2 * NT) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
